pep9_mem_sequencer: RTL and testbench
=====================================

# pep9_mem_sequencer

CPU-side memory access sequencer for the Pep9 bus path. It accepts byte or 16-bit word load/store requests from the Pep9 datapath and splits word accesses into two big-endian byte transactions. It drives the byte-wide APB bridge interface (address, write data, write enable, read data, done), which sits directly downstream. It reassembles read data, enforces a per-byte timeout, and returns a single completion pulse to the CPU.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles `bus_req` stays high for one byte before the access is aborted (range 2..255).
- sysclk  in  1  system clock; all logic rises on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  access request; sampled only while `cpu_ready`=1.
- cpu_addr  in  16  byte address (word: address of the high byte).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_word  in  1  1 = 16-bit word, 0 = single byte.
- cpu_wdata  in  16  store data (byte access uses [7:0]).
- cpu_ready  out  1  sequencer idle, can accept a request.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with `cpu_done`; 1 = timeout abort.
- cpu_rdata  out  16  load result, held from `cpu_done` until the next accept.
- bus_req  out  1  byte transaction active; held until `bus_done`.
- bus_addr  out  16  byte address to the bridge.
- bus_wdata  out  8  byte write data to the bridge.
- bus_we  out  1  byte write enable to the bridge.
- bus_done  in  1  bridge done (level); qualified by `bus_req`.
- bus_rdata  in  8  bridge read byte, valid when `bus_done`=1.

## Operation
- States: IDLE, BYTE0, GAP, BYTE1, RESP.
- IDLE: `cpu_ready`=1. If `cpu_req`=1, latch addr/we/word/wdata, clear `cpu_rdata` and the error flag, and go to BYTE0.
- BYTE0: `bus_req`=1 and `bus_addr`=addr. `bus_wdata` = wdata[15:8] for a word, wdata[7:0] for a byte.
  - On `bus_done` during a word access: latch `bus_rdata` into rdata[15:8], then go to GAP.
  - On `bus_done` during a byte access: rdata = {8'h00, `bus_rdata`}, then go to RESP.
- GAP: `bus_req`=0 for exactly one cycle so the bridge can release done. Then go to BYTE1.
- BYTE1: `bus_req`=1, `bus_addr`=addr+1 (16-bit wrap: FFFF→0000), `bus_wdata`=wdata[7:0]. On `bus_done`: latch rdata[7:0], then go to RESP.
- RESP: `cpu_done`=1 and `cpu_err`=error flag for one cycle, then go to IDLE.
- Store: `cpu_rdata` is 16'h0000.
- `bus_we` equals the latched we in BYTE0/BYTE1 and is 0 elsewhere.
- `bus_addr` and `bus_wdata` are stable for the whole time `bus_req` is high.
- Timeout: the counter clears on entry to BYTE0/BYTE1 and increments each cycle `bus_req`=1 without `bus_done`.
  - If the count reaches TIMEOUT_CYCLES-1 with no `bus_done`: set the error flag, force `cpu_rdata`=0, go to RESP, and skip BYTE1.
  - If `bus_done` arrives in the same cycle as the limit, done wins and there is no error.
- `cpu_req` outside IDLE is ignored. There is no queueing.
- `bus_done` outside BYTE0/BYTE1 is ignored.

## Timing
- Reset (any state, including mid-transaction): next edge → IDLE, `cpu_ready`=1. All other outputs are 0: `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `cpu_done`, `cpu_err`, `cpu_rdata`, counter.
- Accept edge = cycle 0. With zero-wait `bus_done`:
  - Byte access: BYTE0 at cycle 1, `cpu_done` at cycle 2.
  - Word access: BYTE0 at 1, GAP at 2, BYTE1 at 3, `cpu_done` at 4.
- Each bridge wait cycle adds one cycle per byte.
- After `cpu_done` the block is back in IDLE on the next cycle, so the earliest back-to-back accept is 1 cycle after `cpu_done`.
- All outputs are registered, except `cpu_ready`, which decodes state.

## Structure
- Package `pep9_mem_pkg`:
  - state enum `mem_state_t`;
  - width localparams ADDR_W=16, BYTE_W=8, WORD_W=16;
  - default TIMEOUT_CYCLES.
- Sub-module `pep9_bus_timer`:
  - saturating per-byte wait counter with inputs clear and enable;
  - `expired` output;
  - parameter TIMEOUT_CYCLES.
- The top of this block instantiates the FSM plus `pep9_bus_timer`. The bridge stays a separate instance wired by the integrator.

## Test plan
- Byte load at 16'h0040, bridge returns 8'hA5 with zero wait → one bus transaction at 16'h0040 with `bus_we`=0; `cpu_done` at cycle 2; `cpu_rdata`=16'h00A5; `cpu_err`=0.
- Word load at 16'h0100, bridge returns 8'h12 then 8'h34 with 3 wait cycles each → addresses 0100 then 0101; one `bus_req`-low GAP cycle; `cpu_rdata`=16'h1234; `cpu_done` at cycle 10.
- Word store 16'hBEEF at 16'hFFFF → 8'hBE written to FFFF, then 8'hEF written to 0000; `cpu_rdata`=0; `cpu_err`=0.
- Timeout: TIMEOUT_CYCLES=8, word load, `bus_done` never asserted → `bus_req` high 8 cycles; no BYTE1; `cpu_done` with `cpu_err`=1 and `cpu_rdata`=0.
- Reset asserted during BYTE1 of a word store → next cycle `bus_req`=0 and `cpu_ready`=1; no `cpu_done`; the next byte load completes normally.
- `cpu_req` held high through a word access → the second request is accepted only on the cycle after `cpu_done`; the first request's latched fields are unaffected by input changes mid-access.

Source files
------------

// File: rtl/pep9_mem_pkg.sv
// Shared types and widths for the Pep9 CPU-side memory sequencer.
package pep9_mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  // Width of the per-byte wait counter; covers the 2..255 timeout range.
  localparam int unsigned TMR_W = 8;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BYTE0,
    ST_GAP,
    ST_BYTE1,
    ST_RESP
  } mem_state_t;

endpackage

// File: rtl/pep9_bus_timer.sv
// Saturating per-byte wait counter; expired_o flags the last allowed cycle.
module pep9_bus_timer
  import pep9_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  // Count waiting cycles, holding at the limit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + TMR_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/pep9_mem_sequencer.sv
// Splits Pep9 byte/word accesses into big-endian byte transactions on the
// APB bridge interface, reassembles read data and enforces a per-byte timeout.
module pep9_mem_sequencer
  import pep9_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic              cpu_word,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BYTE_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic              bus_done,
  input  logic [BYTE_W-1:0] bus_rdata
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              word_q, word_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  logic              bus_req_q, bus_req_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [BYTE_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_we_q, bus_we_d;
  logic              cpu_done_q, cpu_done_d;
  logic              cpu_err_q, cpu_err_d;
  logic [WORD_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;

  pep9_bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (sysclk),
    .rst_i    (reset),
    .clear_i  (tmr_clr),
    .enable_i (tmr_en),
    .expired_o(tmr_expired)
  );

  // Next-state and registered-output decode; bus outputs are computed one
  // cycle ahead so they are register-driven yet aligned with the state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_we_d    = bus_we_q;
    cpu_done_d  = 1'b0;
    cpu_err_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d      = cpu_addr;
          we_d        = cpu_we;
          word_d      = cpu_word;
          wdata_d     = cpu_wdata;
          cpu_rdata_d = '0;
          bus_req_d   = 1'b1;
          bus_addr_d  = cpu_addr;
          bus_wdata_d = cpu_word ? cpu_wdata[15:8] : cpu_wdata[7:0];
          bus_we_d    = cpu_we;
          tmr_clr     = 1'b1;
          state_d     = ST_BYTE0;
        end
      end

      ST_BYTE0: begin
        tmr_en = !bus_done;
        if (bus_done) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (word_q) begin
            if (!we_q) cpu_rdata_d[15:8] = bus_rdata;
            state_d = ST_GAP;
          end else begin
            if (!we_q) cpu_rdata_d = {8'h00, bus_rdata};
            cpu_done_d = 1'b1;
            state_d    = ST_RESP;
          end
        end else if (tmr_expired) begin
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          cpu_rdata_d = '0;
          cpu_done_d  = 1'b1;
          cpu_err_d   = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_GAP: begin
        bus_req_d   = 1'b1;
        bus_addr_d  = addr_q + ADDR_W'(1);
        bus_wdata_d = wdata_q[7:0];
        bus_we_d    = we_q;
        tmr_clr     = 1'b1;
        state_d     = ST_BYTE1;
      end

      ST_BYTE1: begin
        tmr_en = !bus_done;
        if (bus_done) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (!we_q) cpu_rdata_d[7:0] = bus_rdata;
          cpu_done_d = 1'b1;
          state_d    = ST_RESP;
        end else if (tmr_expired) begin
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          cpu_rdata_d = '0;
          cpu_done_d  = 1'b1;
          cpu_err_d   = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      word_q      <= 1'b0;
      wdata_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      cpu_done_q  <= cpu_done_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign cpu_ready = (state_q == ST_IDLE);
  assign cpu_done  = cpu_done_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_we    = bus_we_q;

endmodule

// File: tb/tb_pep9_mem_sequencer.sv
// Directed bench for pep9_mem_sequencer with a small bridge model.
module tb_pep9_mem_sequencer;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic        cpu_word;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic        cpu_err;
  logic [15:0] cpu_rdata;
  logic        bus_req;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_done;
  logic [7:0]  bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sysclk = ~sysclk;

  pep9_mem_sequencer #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_we   (cpu_we),
    .cpu_word (cpu_word),
    .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready),
    .cpu_done (cpu_done),
    .cpu_err  (cpu_err),
    .cpu_rdata(cpu_rdata),
    .bus_req  (bus_req),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we   (bus_we),
    .bus_done (bus_done),
    .bus_rdata(bus_rdata)
  );

  // Bridge model: done after br_wait wait cycles, data from br_data, logs bytes.
  logic        br_en;
  logic        br_clr;
  logic [7:0]  br_wait;
  logic [7:0]  br_data [4];
  logic [7:0]  br_cnt;
  logic [1:0]  br_idx;
  logic [15:0] tx_addr [8];
  logic [7:0]  tx_wdata[8];
  logic        tx_we   [8];
  logic [3:0]  tx_n;

  assign bus_done  = bus_req && br_en && (br_cnt == br_wait);
  assign bus_rdata = br_data[br_idx];

  always @(posedge sysclk) begin
    if (br_clr) begin
      br_cnt <= 8'd0;
      br_idx <= 2'd0;
      tx_n   <= 4'd0;
    end else begin
      if (bus_req && !bus_done) br_cnt <= br_cnt + 8'd1;
      else                      br_cnt <= 8'd0;
      if (bus_req && bus_done) begin
        br_idx <= br_idx + 2'd1;
        if (tx_n < 4'd8) begin
          tx_addr[tx_n[2:0]]  <= bus_addr;
          tx_wdata[tx_n[2:0]] <= bus_wdata;
          tx_we[tx_n[2:0]]    <= bus_we;
          tx_n                <= tx_n + 4'd1;
        end
      end
    end
  end

  task automatic clr_model();
    br_clr = 1'b1;
    @(negedge sysclk);
    br_clr = 1'b0;
  endtask

  // Issue one request and count cycles after the accept edge until cpu_done.
  task automatic run_access(input logic [15:0] a, input logic we, input logic word,
                            input logic [15:0] wd, output int done_cyc, output int req_cyc);
    @(negedge sysclk);
    cpu_req   = 1'b1;
    cpu_addr  = a;
    cpu_we    = we;
    cpu_word  = word;
    cpu_wdata = wd;
    @(negedge sysclk);
    cpu_req  = 1'b0;
    done_cyc = -1;
    req_cyc  = 0;
    for (int c = 1; c <= 60; c++) begin
      if (bus_req) req_cyc++;
      if (cpu_done) begin
        done_cyc = c;
        break;
      end
      @(negedge sysclk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cpu_ready); end
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
    n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus_we: got %b expected 0", bus_we); end
    n_checks++; if (bus_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_bus_addr: got %h expected 0000", bus_addr); end
    n_checks++; if (bus_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_bus_wdata: got %h expected 00", bus_wdata); end
    n_checks++; if ({cpu_done, cpu_err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b%b expected 00", cpu_done, cpu_err); end
    n_checks++; if (cpu_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", cpu_rdata); end
    reset = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic test_byte_load();
    int dc, rc;
    clr_model();
    br_wait = 8'd0; br_data[0] = 8'hA5;
    run_access(16'h0040, 1'b0, 1'b0, 16'h0000, dc, rc);
    n_checks++; if (dc !== 2) begin n_fail++; $display("FAIL bl_done_cycle: got %0d expected 2", dc); end
    n_checks++; if (cpu_rdata !== 16'h00A5) begin n_fail++; $display("FAIL bl_rdata: got %h expected 00a5", cpu_rdata); end
    n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL bl_err: got %b expected 0", cpu_err); end
    n_checks++; if (rc !== 1) begin n_fail++; $display("FAIL bl_req_cycles: got %0d expected 1", rc); end
    n_checks++; if (tx_n !== 4'd1) begin n_fail++; $display("FAIL bl_tx_count: got %0d expected 1", tx_n); end
    n_checks++; if ({tx_addr[0], tx_we[0]} !== {16'h0040, 1'b0}) begin n_fail++; $display("FAIL bl_tx0: got %h/%b expected 0040/0", tx_addr[0], tx_we[0]); end
  endtask

  task automatic test_word_load_wait();
    int dc, rc;
    clr_model();
    br_wait = 8'd3; br_data[0] = 8'h12; br_data[1] = 8'h34;
    run_access(16'h0100, 1'b0, 1'b1, 16'h0000, dc, rc);
    n_checks++; if (dc !== 10) begin n_fail++; $display("FAIL wl_done_cycle: got %0d expected 10", dc); end
    n_checks++; if (rc !== 8) begin n_fail++; $display("FAIL wl_req_cycles: got %0d expected 8", rc); end
    n_checks++; if (cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL wl_rdata: got %h expected 1234", cpu_rdata); end
    n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL wl_err: got %b expected 0", cpu_err); end
    n_checks++; if ({tx_n, tx_addr[0], tx_addr[1]} !== {4'd2, 16'h0100, 16'h0101}) begin
      n_fail++; $display("FAIL wl_tx: got n=%0d %h %h expected n=2 0100 0101", tx_n, tx_addr[0], tx_addr[1]);
    end
  endtask

  task automatic test_word_store_wrap();
    int dc, rc;
    clr_model();
    br_wait = 8'd0; br_data[0] = 8'h77; br_data[1] = 8'h66;
    run_access(16'hFFFF, 1'b1, 1'b1, 16'hBEEF, dc, rc);
    n_checks++; if (dc !== 4) begin n_fail++; $display("FAIL ws_done_cycle: got %0d expected 4", dc); end
    n_checks++; if (cpu_rdata !== 16'h0000) begin n_fail++; $display("FAIL ws_rdata: got %h expected 0000", cpu_rdata); end
    n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL ws_err: got %b expected 0", cpu_err); end
    n_checks++; if ({tx_addr[0], tx_wdata[0], tx_we[0]} !== {16'hFFFF, 8'hBE, 1'b1}) begin
      n_fail++; $display("FAIL ws_tx0: got %h/%h/%b expected ffff/be/1", tx_addr[0], tx_wdata[0], tx_we[0]);
    end
    n_checks++; if ({tx_addr[1], tx_wdata[1], tx_we[1]} !== {16'h0000, 8'hEF, 1'b1}) begin
      n_fail++; $display("FAIL ws_tx1: got %h/%h/%b expected 0000/ef/1", tx_addr[1], tx_wdata[1], tx_we[1]);
    end
  endtask

  task automatic test_timeout();
    int dc, rc;
    clr_model();
    br_en = 1'b0;
    run_access(16'h0200, 1'b0, 1'b1, 16'h0000, dc, rc);
    n_checks++; if (dc !== 9) begin n_fail++; $display("FAIL to_done_cycle: got %0d expected 9", dc); end
    n_checks++; if (rc !== 8) begin n_fail++; $display("FAIL to_req_cycles: got %0d expected 8", rc); end
    n_checks++; if (cpu_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", cpu_err); end
    n_checks++; if (cpu_rdata !== 16'h0000) begin n_fail++; $display("FAIL to_rdata: got %h expected 0000", cpu_rdata); end
    @(negedge sysclk);
    n_checks++; if ({cpu_ready, bus_req, cpu_err} !== 3'b100) begin
      n_fail++; $display("FAIL to_after: got ready/req/err %b%b%b expected 100", cpu_ready, bus_req, cpu_err);
    end
    br_en = 1'b1;
  endtask

  task automatic test_done_at_limit();
    int dc, rc;
    clr_model();
    br_wait = 8'd7; br_data[0] = 8'h5A;
    run_access(16'h0042, 1'b0, 1'b0, 16'h0000, dc, rc);
    n_checks++; if (dc !== 9) begin n_fail++; $display("FAIL lim_done_cycle: got %0d expected 9", dc); end
    n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL lim_err: got %b expected 0", cpu_err); end
    n_checks++; if (cpu_rdata !== 16'h005A) begin n_fail++; $display("FAIL lim_rdata: got %h expected 005a", cpu_rdata); end
  endtask

  task automatic test_reset_mid();
    int dc, rc;
    bit found;
    int done_seen;
    clr_model();
    br_wait = 8'd2;
    @(negedge sysclk);
    cpu_req = 1'b1; cpu_addr = 16'h1000; cpu_we = 1'b1; cpu_word = 1'b1; cpu_wdata = 16'h5678;
    @(negedge sysclk);
    cpu_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus_req && bus_addr == 16'h1001) begin
        found = 1'b1;
        break;
      end
      @(negedge sysclk);
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rm_reach_byte1: got %b expected 1", found); end
    reset = 1'b1;
    @(negedge sysclk);
    n_checks++; if ({bus_req, cpu_ready, cpu_done} !== 3'b010) begin
      n_fail++; $display("FAIL rm_after_reset: got req/ready/done %b%b%b expected 010", bus_req, cpu_ready, cpu_done);
    end
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge sysclk);
      if (cpu_done) done_seen++;
    end
    n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL rm_no_done: got %0d expected 0", done_seen); end
    clr_model();
    br_wait = 8'd0; br_data[0] = 8'h3C;
    run_access(16'h0041, 1'b0, 1'b0, 16'h0000, dc, rc);
    n_checks++; if (dc !== 2) begin n_fail++; $display("FAIL rm_next_done: got %0d expected 2", dc); end
    n_checks++; if (cpu_rdata !== 16'h003C) begin n_fail++; $display("FAIL rm_next_rdata: got %h expected 003c", cpu_rdata); end
  endtask

  task automatic test_back_to_back();
    int dc;
    int early_ready;
    clr_model();
    br_wait = 8'd0; br_data[0] = 8'hAB; br_data[1] = 8'hCD;
    @(negedge sysclk);
    cpu_req = 1'b1; cpu_addr = 16'h0200; cpu_we = 1'b0; cpu_word = 1'b1; cpu_wdata = 16'h0000;
    @(negedge sysclk);
    cpu_addr = 16'h0300; cpu_we = 1'b1; cpu_word = 1'b0; cpu_wdata = 16'h1111;
    dc = -1; early_ready = 0;
    for (int c = 1; c <= 20; c++) begin
      if (cpu_ready) early_ready++;
      if (cpu_done) begin
        dc = c;
        break;
      end
      @(negedge sysclk);
    end
    n_checks++; if (dc !== 4) begin n_fail++; $display("FAIL bb_done_cycle: got %0d expected 4", dc); end
    n_checks++; if (early_ready !== 0) begin n_fail++; $display("FAIL bb_ready_busy: got %0d expected 0", early_ready); end
    n_checks++; if (cpu_rdata !== 16'hABCD) begin n_fail++; $display("FAIL bb_rdata: got %h expected abcd", cpu_rdata); end
    n_checks++; if ({tx_addr[0], tx_we[0], tx_addr[1], tx_we[1]} !== {16'h0200, 1'b0, 16'h0201, 1'b0}) begin
      n_fail++; $display("FAIL bb_first_tx: got %h/%b %h/%b expected 0200/0 0201/0", tx_addr[0], tx_we[0], tx_addr[1], tx_we[1]);
    end
    @(negedge sysclk);
    n_checks++; if ({cpu_ready, bus_req} !== 2'b10) begin
      n_fail++; $display("FAIL bb_idle_cycle: got ready/req %b%b expected 10", cpu_ready, bus_req);
    end
    @(negedge sysclk);
    cpu_req = 1'b0;
    n_checks++; if ({bus_req, bus_addr, bus_we, bus_wdata} !== {1'b1, 16'h0300, 1'b1, 8'h11}) begin
      n_fail++; $display("FAIL bb_second_byte0: got %b/%h/%b/%h expected 1/0300/1/11", bus_req, bus_addr, bus_we, bus_wdata);
    end
    @(negedge sysclk);
    n_checks++; if ({cpu_done, cpu_rdata} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL bb_second_done: got %b/%h expected 1/0000", cpu_done, cpu_rdata);
    end
    n_checks++; if (tx_n !== 4'd3) begin n_fail++; $display("FAIL bb_tx_count: got %0d expected 3", tx_n); end
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_word = 1'b0; cpu_wdata = '0;
    br_en = 1'b1; br_clr = 1'b1; br_wait = 8'd0;
    for (int i = 0; i < 4; i++) br_data[i] = 8'h00;
    test_reset();
    test_byte_load();
    test_word_load_wait();
    test_word_store_wrap();
    test_timeout();
    test_done_at_limit();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
